// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: funct codes, ALU op enum, flag indices.
// Optional shift ops are enabled by defining EXECUTE_SHIFT_EN.
package execute_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned FLAG_W  = 4;

  localparam logic [FUNCT_W-1:0] FUNCT_SLLV = 6'h04;
  localparam logic [FUNCT_W-1:0] FUNCT_SRLV = 6'h06;
  localparam logic [FUNCT_W-1:0] FUNCT_SRAV = 6'h07;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'h2B;

  // Flag vector layout is {N, Z, C, V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLLV,
    ALU_SRLV,
    ALU_SRAV,
    ALU_NONE
  } alu_op_t;

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU: result and {N, Z, C, V} flags for the decoded operation.
module execute_alu
  import execute_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags
);

  logic [DATA_W:0]   sum_c;
  logic [DATA_W:0]   diff_c;
  logic              carry_c;
  logic              ovf_c;
  logic [DATA_W-1:0] res_c;

  // Carry of the subtract path is the inverted borrow (A + ~B + 1)
  assign sum_c  = {1'b0, a} + {1'b0, b};
  assign diff_c = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (op)
      ALU_ADD: begin
        res_c   = sum_c[DATA_W-1:0];
        carry_c = sum_c[DATA_W];
        ovf_c   = (a[DATA_W-1] == b[DATA_W-1]) && (sum_c[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        res_c   = diff_c[DATA_W-1:0];
        carry_c = diff_c[DATA_W];
        ovf_c   = (a[DATA_W-1] != b[DATA_W-1]) && (diff_c[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND:  res_c = a & b;
      ALU_OR:   res_c = a | b;
      ALU_XOR:  res_c = a ^ b;
      ALU_NOR:  res_c = ~(a | b);
      ALU_SLT: begin
        res_c   = DATA_W'($signed(a) < $signed(b));
        carry_c = diff_c[DATA_W];
      end
      ALU_SLTU: begin
        res_c   = DATA_W'(a < b);
        carry_c = diff_c[DATA_W];
      end
      ALU_SLLV: res_c = b << a[4:0];
      ALU_SRLV: res_c = b >> a[4:0];
      ALU_SRAV: res_c = DATA_W'($signed(b) >>> a[4:0]);
      default:  res_c = '0;
    endcase
  end

  assign result         = res_c;
  assign flags[FLAG_N]  = res_c[DATA_W-1];
  assign flags[FLAG_Z]  = (res_c == '0);
  assign flags[FLAG_C]  = carry_c;
  assign flags[FLAG_V]  = ovf_c;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand mux, funct decode, ALU, branch adder, dest mux, EX/MEM register.
// Define EXECUTE_SHIFT_EN to enable SLLV/SRLV/SRAV.
module execute_stage
  import execute_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  PC_next,
  input  logic [DATA_W-1:0]  reg1,
  input  logic [DATA_W-1:0]  reg2,
  input  logic [DATA_W-1:0]  ext_immediate,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic               ctr_reg_dest,
  input  logic               ctr_alu_op,
  input  logic               ctr_alu_src,
  output logic [DATA_W-1:0]  branch_out,
  output logic [DATA_W-1:0]  alu,
  output logic [FLAG_W-1:0]  flags,
  output logic [DATA_W-1:0]  reg2_out,
  output logic [REG_W-1:0]   wsel
);

  logic [DATA_W-1:0] op_b_c;
  logic [DATA_W-1:0] branch_c;
  logic [DATA_W-1:0] alu_result_c;
  logic [FLAG_W-1:0] alu_flags_c;
  logic [REG_W-1:0]  wsel_c;
  alu_op_t           alu_op_c;

  assign op_b_c   = ctr_alu_src ? ext_immediate : reg2;
  assign branch_c = PC_next + {ext_immediate[DATA_W-3:0], 2'b00};
  assign wsel_c   = ctr_reg_dest ? rd : rt;

  // Non-R-type instructions always add (address and immediate arithmetic)
  always_comb begin
    alu_op_c = ALU_ADD;
    if (ctr_alu_op) begin
      case (funct)
        FUNCT_ADD, FUNCT_ADDU: alu_op_c = ALU_ADD;
        FUNCT_SUB, FUNCT_SUBU: alu_op_c = ALU_SUB;
        FUNCT_AND:             alu_op_c = ALU_AND;
        FUNCT_OR:              alu_op_c = ALU_OR;
        FUNCT_XOR:             alu_op_c = ALU_XOR;
        FUNCT_NOR:             alu_op_c = ALU_NOR;
        FUNCT_SLT:             alu_op_c = ALU_SLT;
        FUNCT_SLTU:            alu_op_c = ALU_SLTU;
`ifdef EXECUTE_SHIFT_EN
        FUNCT_SLLV:            alu_op_c = ALU_SLLV;
        FUNCT_SRLV:            alu_op_c = ALU_SRLV;
        FUNCT_SRAV:            alu_op_c = ALU_SRAV;
`endif
        default:               alu_op_c = ALU_NONE;
      endcase
    end
  end

  execute_alu u_alu (
    .a      (reg1),
    .b      (op_b_c),
    .op     (alu_op_c),
    .result (alu_result_c),
    .flags  (alu_flags_c)
  );

  // EX/MEM pipeline register, loads every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_out <= '0;
      alu        <= '0;
      flags      <= '0;
      reg2_out   <= '0;
      wsel       <= '0;
    end else begin
      branch_out <= branch_c;
      alu        <= alu_result_c;
      flags      <= alu_flags_c;
      reg2_out   <= reg2;
      wsel       <= wsel_c;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed plan plus randomized stimulus vs. an arithmetic model.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic [31:0] PC_next, reg1, reg2, ext_immediate;
  logic [5:0]  funct;
  logic [4:0]  rt, rd;
  logic        ctr_reg_dest, ctr_alu_op, ctr_alu_src;
  logic [31:0] branch_out, alu, reg2_out;
  logic [3:0]  flags;
  logic [4:0]  wsel;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_branch, exp_alu, exp_reg2;
  logic [3:0]  exp_flags;
  logic [4:0]  exp_wsel;

  execute_stage dut (
    .clk           (clk),
    .reset         (reset),
    .PC_next       (PC_next),
    .reg1          (reg1),
    .reg2          (reg2),
    .ext_immediate (ext_immediate),
    .funct         (funct),
    .rt            (rt),
    .rd            (rd),
    .ctr_reg_dest  (ctr_reg_dest),
    .ctr_alu_op    (ctr_alu_op),
    .ctr_alu_src   (ctr_alu_src),
    .branch_out    (branch_out),
    .alu           (alu),
    .flags         (flags),
    .reg2_out      (reg2_out),
    .wsel          (wsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".alu"},      alu,             exp_alu);
    check({tag, ".flags"},    32'(flags),      32'(exp_flags));
    check({tag, ".branch"},   branch_out,      exp_branch);
    check({tag, ".reg2_out"}, reg2_out,        exp_reg2);
    check({tag, ".wsel"},     32'(wsel),       32'(exp_wsel));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".alu"},      alu,        32'h0);
    check({tag, ".flags"},    32'(flags), 32'h0);
    check({tag, ".branch"},   branch_out, 32'h0);
    check({tag, ".reg2_out"}, reg2_out,   32'h0);
    check({tag, ".wsel"},     32'(wsel),  32'h0);
  endtask

  // Reference ALU built from plain integer arithmetic on 64-bit values
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input bit op,
                                  input logic [5:0] fn, output logic [31:0] r, output logic [3:0] f);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    bit c = 1'b0;
    bit v = 1'b0;
    logic [5:0] code = op ? fn : 6'h20;
    r = 32'h0;
    case (code)
      6'h20, 6'h21: begin
        r = 32'(ua + ub);
        c = (ua + ub) > 64'hFFFF_FFFF;
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h22, 6'h23: begin
        r = 32'(ua - ub);
        c = (ua >= ub);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: begin r = (sa < sb) ? 32'd1 : 32'd0; c = (ua >= ub); end
      6'h2B: begin r = (ua < ub) ? 32'd1 : 32'd0; c = (ua >= ub); end
`ifdef EXECUTE_SHIFT_EN
      6'h04: r = 32'(ub << a[4:0]);
      6'h06: r = 32'(ub >> a[4:0]);
      6'h07: r = 32'(sb >>> a[4:0]);
`endif
      default: r = 32'h0;
    endcase
    f = {r[31], (r == 32'h0), c, v};
  endfunction

  task automatic compute_exp();
    logic [31:0] bsel;
    bsel = ctr_alu_src ? ext_immediate : reg2;
    ref_alu(reg1, bsel, ctr_alu_op, funct, exp_alu, exp_flags);
    exp_branch = 32'(64'(PC_next) + 64'(ext_immediate) * 4);
    exp_reg2   = reg2;
    exp_wsel   = ctr_reg_dest ? rd : rt;
  endtask

  task automatic randomize_inputs();
    logic [5:0]  codes [14];
    logic [31:0] edges [5];
    codes = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h3F};
    edges = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
    PC_next       = $urandom;
    reg1          = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 32'($urandom);
    reg2          = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 32'($urandom);
    ext_immediate = 32'($signed(16'($urandom)));
    funct         = ($urandom_range(0, 4) == 0) ? 6'($urandom) : codes[$urandom_range(0, 13)];
    rt            = 5'($urandom);
    rd            = 5'($urandom);
    ctr_reg_dest  = 1'($urandom);
    ctr_alu_op    = ($urandom_range(0, 3) != 0);
    ctr_alu_src   = 1'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    randomize_inputs();

    // Reset held low across several edges with changing inputs
    for (int i = 0; i < 3; i++) begin
      step();
      check_zero("reset_hold");
      randomize_inputs();
    end

    PC_next = 32'd64; reg1 = 32'd8; reg2 = 32'd8; ext_immediate = 32'd16;
    rt = 5'd2; rd = 5'd4; funct = 6'h00;
    ctr_reg_dest = 1'b0; ctr_alu_op = 1'b0; ctr_alu_src = 1'b0;
    #1 reset = 1'b1;
    #1 check_zero("release_before_edge");

    step();
    check("p2.alu", alu, 32'd16);
    check("p2.wsel", 32'(wsel), 32'd2);
    check("p2.branch", branch_out, 32'd128);
    check("p2.reg2_out", reg2_out, 32'd8);
    check("p2.flags", 32'(flags), 32'h0);

    ctr_reg_dest = 1'b1; ctr_alu_src = 1'b1;
    step();
    check("p3.alu", alu, 32'd24);
    check("p3.wsel", 32'(wsel), 32'd4);
    check("p3.reg2_out", reg2_out, 32'd8);
    check("p3.flags", 32'(flags), 32'h0);

    ctr_reg_dest = 1'b0; ctr_alu_op = 1'b1; ctr_alu_src = 1'b0; funct = 6'h22;
    step();
    check("p4.alu", alu, 32'd0);
    check("p4.flags", 32'(flags), 32'b0110);

    reg1 = 32'hFFFF_FFFF; reg2 = 32'd1; funct = 6'h2A;
    step();
    check("p5.slt", alu, 32'd1);
    funct = 6'h2B;
    step();
    check("p5.sltu", alu, 32'd0);
    check("p5.sltu_flags", 32'(flags), 32'b0110);

    reg1 = 32'h7FFF_FFFF; reg2 = 32'd1; funct = 6'h20;
    step();
    check("p6.add_ovf", alu, 32'h8000_0000);
    check("p6.add_ovf_flags", 32'(flags), 32'b1001);
    funct = 6'h3F;
    step();
    check("p6.bad_funct", alu, 32'h0);
    check("p6.bad_funct_flags", 32'(flags), 32'b0100);

    reg1 = 32'd4; reg2 = 32'h8000_0010; funct = 6'h07;
    step();
`ifdef EXECUTE_SHIFT_EN
    check("srav", alu, 32'hF800_0001);
    check("srav_flags", 32'(flags), 32'b1000);
`else
    check("srav_off", alu, 32'h0);
    check("srav_off_flags", 32'(flags), 32'b0100);
`endif

    // Randomized traffic; each cycle also checks that mid-cycle input changes are invisible
    randomize_inputs();
    compute_exp();
    for (int i = 0; i < 300; i++) begin
      step();
      check_all("rand");
      randomize_inputs();
      #2 check_all("hold_between_edges");
      if (i == 150) begin
        reset = 1'b0;
        #1 check_zero("async_reset");
        step();
        check_zero("reset_edge");
        randomize_inputs();
        #1 reset = 1'b1;
        #1 check_zero("after_release");
      end
      compute_exp();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
